// File: rtl/frac_clken_gen.sv
// ---------------------------------------------------------------------------
// frac_clken_gen
//
// Multi-channel fractional clock-enable generator with lock-gated reset
// sequencing. Runs entirely on one PLL output (refclk) and produces CHANNELS
// enable strobes. Each strobe averages refclk * NUM / DEN, which lets the core
// derive its CPU, video and sound clocks without extra PLL outputs. The core
// is held in reset until the PLL has been locked for LOCK_HOLD cycles. Reset
// is reasserted whenever lock is lost.
//
// Ports
//   refclk      in   master clock (PLL output)
//   rst         in   asynchronous active-high reset
//   pll_locked  in   PLL lock indication, asynchronous to refclk
//   cfg_we      in   one-cycle configuration write strobe
//   cfg_ch      in   channel being written (values >= CHANNELS are ignored)
//   cfg_num     in   numerator for the written channel
//   cfg_den     in   denominator for the written channel (0 disables it)
//   ce          out  registered enable strobes, bit i belongs to channel i
//   core_rst    out  registered synchronous reset for the core
//   ready       out  high while the sequencer is in RUN
// ---------------------------------------------------------------------------
module frac_clken_gen #(
    parameter int CHANNELS  = 4,
    parameter int ACC_W     = 16,
    parameter int LOCK_HOLD = 1024,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int HC_W     = $clog2(LOCK_HOLD)
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                pll_locked,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [ACC_W-1:0]    cfg_num,
    input  logic [ACC_W-1:0]    cfg_den,
    output logic [CHANNELS-1:0] ce,
    output logic                core_rst,
    output logic                ready
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [HC_W-1:0]     hold_cnt;
    logic [HC_W-1:0]     hold_next;
    logic                lk_meta;
    logic                lk;

    logic [CHANNELS-1:0][ACC_W-1:0] num_r;
    logic [CHANNELS-1:0][ACC_W-1:0] den_r;
    logic [CHANNELS-1:0][ACC_W-1:0] acc_r;
    logic [CHANNELS-1:0][ACC_W:0]   sum;
    logic [CHANNELS-1:0][ACC_W-1:0] wrap;

    // Two-flop synchronizer bringing the PLL lock flag into the refclk domain.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lk_meta <= 1'b0;
            lk      <= 1'b0;
        end else begin
            lk_meta <= pll_locked;
            lk      <= lk_meta;
        end
    end

    // Sequencer state and the lock-stability counter.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state    <= WAIT_LOCK;
            hold_cnt <= '0;
        end else begin
            state    <= next_state;
            hold_cnt <= hold_next;
        end
    end

    // Next-state logic. HOLD must see lock continuously for LOCK_HOLD cycles
    // (hold_cnt 0 .. LOCK_HOLD-1) before the core is released.
    always_comb begin
        next_state = state;
        hold_next  = hold_cnt;
        case (state)
            WAIT_LOCK: begin
                hold_next = '0;
                if (lk) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                hold_next = hold_cnt + HC_W'(1);
                if (!lk) begin
                    next_state = WAIT_LOCK;
                    hold_next  = '0;
                end else if (hold_cnt == HC_W'(LOCK_HOLD - 1)) begin
                    next_state = RUN;
                    hold_next  = '0;
                end
            end
            RUN: begin
                hold_next = '0;
                if (!lk) begin
                    next_state = WAIT_LOCK;
                end
            end
            default: begin
                next_state = WAIT_LOCK;
                hold_next  = '0;
            end
        endcase
    end

    // core_rst and ready are registered from the next state so that a lock
    // loss seen on lk asserts core_rst on the very next edge.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            core_rst <= 1'b1;
            ready    <= 1'b0;
        end else begin
            core_rst <= (next_state != RUN);
            ready    <= (next_state == RUN);
        end
    end

    // Per-channel candidate accumulator values. The sum is one bit wider so
    // the comparison against DEN never overflows; the wrapped value is exact
    // modulo 2^ACC_W because acc < DEN and the true result is below DEN.
    always_comb begin
        sum  = '0;
        wrap = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sum[i]  = {1'b0, acc_r[i]} + {1'b0, num_r[i]};
            wrap[i] = acc_r[i] + num_r[i] - den_r[i];
        end
    end

    // Channel registers. A configuration write takes priority and restarts
    // its channel from acc=0. Outside RUN every accumulator is held at zero
    // so all channels restart phase-aligned. NUM >= DEN clamps to a strobe
    // on every cycle; DEN == 0 disables the channel.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            num_r <= '0;
            den_r <= '0;
            acc_r <= '0;
            ce    <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (cfg_we && (cfg_ch == CH_W'(i))) begin
                    num_r[i] <= cfg_num;
                    den_r[i] <= cfg_den;
                    acc_r[i] <= '0;
                    ce[i]    <= 1'b0;
                end else if (state != RUN) begin
                    acc_r[i] <= '0;
                    ce[i]    <= 1'b0;
                end else if (den_r[i] == '0) begin
                    ce[i]    <= 1'b0;
                end else if (num_r[i] >= den_r[i]) begin
                    acc_r[i] <= '0;
                    ce[i]    <= 1'b1;
                end else if (sum[i] >= {1'b0, den_r[i]}) begin
                    acc_r[i] <= wrap[i];
                    ce[i]    <= 1'b1;
                end else begin
                    acc_r[i] <= sum[i][ACC_W-1:0];
                    ce[i]    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_frac_clken_gen.sv
// ---------------------------------------------------------------------------
// tb_frac_clken_gen
//
// Scoreboard bench for frac_clken_gen with CHANNELS=5, LOCK_HOLD=16. Each
// stimulus step drives inputs on the falling edge and queues the outputs
// expected after the following rising edge; a monitor pops and compares one
// entry per cycle. Expected strobe patterns are hand-computed tables.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_frac_clken_gen;

    localparam int CHANNELS  = 5;
    localparam int ACC_W     = 16;
    localparam int LOCK_HOLD = 16;
    localparam int CH_W      = 3;

    logic                refclk = 1'b0;
    logic                rst;
    logic                pll_locked;
    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [ACC_W-1:0]    cfg_num;
    logic [ACC_W-1:0]    cfg_den;
    logic [CHANNELS-1:0] ce;
    logic                core_rst;
    logic                ready;

    typedef struct packed {
        logic [4:0] mask;
        logic [4:0] cev;
        logic       chk_ctl;
        logic       rdy;
        logic       crst;
        logic       cnt;
        int         tst;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   failures   = 0;
    int   strobe_cnt = 0;

    // NUM=3/DEN=8 pattern from the first ce cycle (bit0 = cycle 1): 0,0,1,0,0,1,0,1
    logic [7:0] p38 = 8'b1010_0100;
    // NUM=1/DEN=4 pattern from the first ce cycle: 0,0,0,1
    logic [3:0] p14 = 4'b1000;

    frac_clken_gen #(
        .CHANNELS  (CHANNELS),
        .ACC_W     (ACC_W),
        .LOCK_HOLD (LOCK_HOLD)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_num    (cfg_num),
        .cfg_den    (cfg_den),
        .ce         (ce),
        .core_rst   (core_rst),
        .ready      (ready)
    );

    always #5 refclk = ~refclk;

    function automatic exp_t mk(input int tst, input int cyc, input logic [4:0] mask,
                                input logic [4:0] cev, input logic chk, input logic rdy,
                                input logic crst, input logic cnt);
        exp_t e;
        e.mask    = mask;
        e.cev     = cev;
        e.chk_ctl = chk;
        e.rdy     = rdy;
        e.crst    = crst;
        e.cnt     = cnt;
        e.tst     = tst;
        e.cyc     = cyc;
        return e;
    endfunction

    task automatic checkOutput(input exp_t e);
        checks++;
        if (((ce & e.mask) !== (e.cev & e.mask)) ||
            (e.chk_ctl && ((ready !== e.rdy) || (core_rst !== e.crst)))) begin
            failures++;
            $display("[TB] FAIL T%0d cyc%0d: got ce=%b ready=%b core_rst=%b, expected ce=%b (mask %b) ready=%b core_rst=%b",
                     e.tst, e.cyc, ce, ready, core_rst, e.cev, e.mask, e.rdy, e.crst);
        end
    endtask

    task automatic checkCount(input int tst, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("[TB] FAIL T%0d strobe_count: got %0d, expected %0d", tst, got, want);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic lock, input logic we,
                                 input logic [CH_W-1:0] ch, input logic [ACC_W-1:0] num,
                                 input logic [ACC_W-1:0] den, input exp_t e);
        @(negedge refclk);
        rst        = r;
        pll_locked = lock;
        cfg_we     = we;
        cfg_ch     = ch;
        cfg_num    = num;
        cfg_den    = den;
        sb.push_back(e);
    endtask

    // Release from reset with lock present: lk at edge 2, HOLD from edge 3,
    // RUN (ready high, core_rst low) at edge 2+16+1 = 19. Optional channel
    // writes land during HOLD.
    task automatic releaseSeq(input int tst, input bit do_cfg);
        for (int c = 1; c <= 19; c++) begin
            logic            we;
            logic [CH_W-1:0] ch;
            logic [ACC_W-1:0] num;
            logic [ACC_W-1:0] den;
            we  = 1'b0;
            ch  = 3'd0;
            num = 16'd0;
            den = 16'd0;
            if (do_cfg) begin
                case (c)
                    4: begin we = 1'b1; ch = 3'd0; num = 16'd3; den = 16'd8; end
                    5: begin we = 1'b1; ch = 3'd1; num = 16'd9; den = 16'd0; end
                    6: begin we = 1'b1; ch = 3'd2; num = 16'd5; den = 16'd5; end
                    7: begin we = 1'b1; ch = 3'd3; num = 16'd7; den = 16'd3; end
                    8: begin we = 1'b1; ch = 3'd5; num = 16'd1; den = 16'd1; end
                    default: ;
                endcase
            end
            applyStimulus(1'b0, 1'b1, we, ch, num, den,
                          mk(tst, c, 5'b11111, 5'b00000, 1'b1, (c == 19), (c != 19), 1'b0));
        end
    endtask

    // Monitor: one comparison per cycle whenever an expectation is pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge refclk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e);
                if (e.cnt && ce[0]) begin
                    strobe_cnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0] cev;
        rst        = 1'b1;
        pll_locked = 1'b0;
        cfg_we     = 1'b0;
        cfg_ch     = 3'd0;
        cfg_num    = 16'd0;
        cfg_den    = 16'd0;

        // Reset state
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0,
                          mk(0, c, 5'b11111, 5'b00000, 1'b1, 1'b0, 1'b1, 1'b0));
        end

        // T1 release timing, with channel setup during HOLD
        releaseSeq(1, 1'b1);

        // T2/T3: ch0 3/8, ch1 disabled, ch2 5/5 and ch3 7/3 clamped, ch4 never written
        for (int r = 1; r <= 1000; r++) begin
            cev = {1'b0, 1'b1, 1'b1, 1'b0, p38[(r - 1) % 8]};
            applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 16'd0, 16'd0,
                          mk(2, r, 5'b11111, cev, 1'b1, 1'b1, 1'b0, 1'b1));
        end
        @(posedge refclk);
        #2;
        checkCount(2, strobe_cnt, 375);

        // T4 one-cycle lock drop; RUN continues two edges, then a full re-wait
        for (int j = 1; j <= 20; j++) begin
            logic            lock;
            logic            we;
            exp_t            e;
            lock = (j != 1);
            we   = (j == 6);
            if (j <= 2) begin
                cev = {1'b0, 1'b1, 1'b1, 1'b0, p38[(1000 + j - 1) % 8]};
                e   = mk(4, j, 5'b11111, cev, 1'b1, 1'b1, 1'b0, 1'b0);
            end else if (j == 3) begin
                e   = mk(4, j, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b1, 1'b0);
            end else begin
                e   = mk(4, j, 5'b11111, 5'b00000, 1'b1, (j == 20), (j != 20), 1'b0);
            end
            applyStimulus(1'b0, lock, we, 3'd1, we ? 16'd1 : 16'd0, we ? 16'd4 : 16'd0, e);
        end

        // T4 restart pattern and T5 live reconfiguration at r=41, ignored writes at r=50/51
        for (int r = 1; r <= 60; r++) begin
            logic            we;
            logic [CH_W-1:0] ch;
            logic [ACC_W-1:0] num;
            logic [ACC_W-1:0] den;
            logic            c0;
            we  = 1'b0;
            ch  = 3'd0;
            num = 16'd0;
            den = 16'd0;
            if (r == 41) begin we = 1'b1; ch = 3'd0; num = 16'd1; den = 16'd2; end
            if (r == 50) begin we = 1'b1; ch = 3'd5; num = 16'd1; den = 16'd1; end
            if (r == 51) begin we = 1'b1; ch = 3'd7; num = 16'd1; den = 16'd1; end
            if (r < 41) begin
                c0 = p38[(r - 1) % 8];
            end else begin
                c0 = (r >= 43) && ((r % 2) == 1);
            end
            cev = {1'b0, 1'b1, 1'b1, p14[(r - 1) % 4], c0};
            applyStimulus(1'b0, 1'b1, we, ch, num, den,
                          mk((r <= 40) ? 4 : 5, r, 5'b11111, cev, 1'b1, 1'b1, 1'b0, 1'b0));
        end

        // T6 async reset pulse mid-run
        @(posedge refclk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput(mk(6, 0, 5'b11111, 5'b00000, 1'b1, 1'b0, 1'b1, 1'b0));
        releaseSeq(6, 1'b0);
        for (int r = 1; r <= 20; r++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 16'd0, 16'd0,
                          mk(6, 100 + r, 5'b11111, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0));
        end

        // Drain: every queued expectation must have been compared
        @(posedge refclk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d pending entries, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
